azadi_pad_in_cond: RTL
======================

Name: azadi_pad_in_cond

Overview:
- Receive-side conditioner for the chip's pad input bus.
- Takes the raw per-pad input values coming up from the pad ring (pad C outputs) together with the per-pad output-enable state.
- Produces, for every pad:
  - a 2-flop synchronised copy;
  - an optionally debounced copy;
  - rise and fall strobes;
  - sticky edge interrupt status.
- Sits between the pad ring and the GPIO/peripheral input muxing inside the core.

Parameters:
- NUM_IO, 54, number of pads handled.
- DEB_CNT_W, 16, width of per-pad debounce counter and of deb_limit_i.
- RST_VAL, 54'h2_A000_0001, reset value of synchroniser/filter flops per pad; bits 0, 29, 31, 33 are 1 to match the pull-up pads.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  asynchronous, active-high reset.
- io_in_i  input  NUM_IO  raw pad input values (asynchronous to clk_i).
- io_oeb_i  input  NUM_IO  pad output-enable, active-low; 1 = pad is an input.
- deb_en_i  input  NUM_IO  per-pad debounce enable.
- deb_limit_i  input  DEB_CNT_W  shared stable-cycle count required before the filtered value changes.
- irq_rise_en_i  input  NUM_IO  rising-edge interrupt enable.
- irq_fall_en_i  input  NUM_IO  falling-edge interrupt enable.
- irq_clr_i  input  NUM_IO  write-1-to-clear pulse for irq_status_o.
- pin_sync_o  output  NUM_IO  2-flop synchronised pad value.
- pin_filt_o  output  NUM_IO  debounced (or bypassed) pad value.
- rise_o  output  NUM_IO  1-cycle strobe, pin_filt_o went 0->1.
- fall_o  output  NUM_IO  1-cycle strobe, pin_filt_o went 1->0.
- irq_status_o  output  NUM_IO  sticky edge-event status.
- irq_o  output  1  OR of irq_status_o.

Behaviour:

Reset (async, rst_i=1):
- sync stage 1, sync stage 2 (pin_sync_o), pin_filt_o and filt_d = RST_VAL.
- Counters = 0.
- irq_status_o = 0.
- rise_o, fall_o and irq_o are therefore 0.
- Reset mid-count discards the count.
- No edge strobe on the first cycle after reset release.

Synchroniser:
- Two flops per pad, no reset-to-data path other than RST_VAL.
- io_in_i change appears on pin_sync_o after 2 rising edges.

Filter, per pad n, evaluated each edge with mism = pin_sync_o[n] != pin_filt_o[n]:
- deb_en_i[n]=0: pin_filt_o[n] <= pin_sync_o[n]; cnt[n] <= 0.
- deb_en_i[n]=1 and !mism: cnt[n] <= 0.
- deb_en_i[n]=1 and mism and (cnt[n]+1 >= deb_limit_i or deb_limit_i==0): pin_filt_o[n] <= pin_sync_o[n]; cnt[n] <= 0.
- otherwise: cnt[n] <= cnt[n]+1.
- Net latency io_in_i -> pin_filt_o:
  - 3 edges when bypassed or limit 0/1;
  - 2+L edges for limit L>=1.
- A glitch shorter than L cycles at pin_sync_o never reaches pin_filt_o.
- deb_limit_i changing mid-count takes effect immediately; the >= compare guarantees no counter overrun or wrap.
- cnt+1 is computed at DEB_CNT_W+1 bits.

Edges:
- filt_d <= pin_filt_o every edge.
- rise_o = pin_filt_o & ~filt_d; fall_o = ~pin_filt_o & filt_d.
- Each strobe is high exactly one cycle, coincident with the new filtered value.
- Strobes are generated regardless of io_oeb_i.

Interrupt status:
- Set condition: ev[n] = io_oeb_i[n] & ((rise_o[n] & irq_rise_en_i[n]) | (fall_o[n] & irq_fall_en_i[n])).
- irq_status_o[n] <= ev[n] ? 1 : (irq_clr_i[n] ? 0 : irq_status_o[n]).
- Set wins over a simultaneous clear.
- Edges on pads in output mode (io_oeb_i=0) never set status.
- irq_o is combinational OR of the irq_status_o flops.

Test Plan:
- Reset release, io_in_i = RST_VAL held -> pin_sync_o = pin_filt_o = 54'h2_A000_0001; rise_o, fall_o, irq_o stay 0 for 20 cycles.
- Pad 5, deb_en=0, io_in_i[5] 0->1 -> pin_sync_o[5]=1 after 2 edges; pin_filt_o[5] and rise_o[5] after 3 edges; rise_o[5] high exactly 1 cycle.
- Pad 2, deb_en=1, deb_limit=4:
  - 3-cycle high pulse at pin_sync_o[2] -> pin_filt_o[2] stays 0, no strobe.
  - Held high -> pin_filt_o[2]=1 on the 4th edge after pin_sync_o[2] rose.
- Pad 7, irq_fall_en=1, io_oeb=1, filtered 1->0 -> irq_status_o[7]=1, irq_o=1. irq_clr_i[7] pulse -> status 0. Clear asserted in the same cycle as a new fall -> status stays 1.
- Pad 9, io_oeb_i[9]=0, irq_rise_en=1, rising edge -> rise_o[9] pulses, irq_status_o[9] stays 0.
- Pad 3, deb_limit=10, mismatch counted to 6, deb_limit changed to 5 -> pin_filt_o[3] updates on the next mismatching edge. rst_i asserted mid-count -> counter 0 and filt = RST_VAL[3] immediately.

Source files
------------

// File: rtl/azadi_pad_in_cond.sv
`default_nettype none
// ============================================================================
//  Module   : azadi_pad_in_cond
//  Purpose  : Receive-side conditioner for the pad input bus. Per pad it
//             provides a 2-flop synchronised value, an optionally debounced
//             value, rise/fall strobes and sticky edge interrupt status.
//  Revision : 1.0  initial release
// ============================================================================
module azadi_pad_in_cond #(
    parameter int                NUM_IO    = 54,
    parameter int                DEB_CNT_W = 16,
    parameter logic [NUM_IO-1:0] RST_VAL   = 54'h2_A000_0001
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_IO-1:0]    io_in_i,
    input  logic [NUM_IO-1:0]    io_oeb_i,
    input  logic [NUM_IO-1:0]    deb_en_i,
    input  logic [DEB_CNT_W-1:0] deb_limit_i,
    input  logic [NUM_IO-1:0]    irq_rise_en_i,
    input  logic [NUM_IO-1:0]    irq_fall_en_i,
    input  logic [NUM_IO-1:0]    irq_clr_i,
    output logic [NUM_IO-1:0]    pin_sync_o,
    output logic [NUM_IO-1:0]    pin_filt_o,
    output logic [NUM_IO-1:0]    rise_o,
    output logic [NUM_IO-1:0]    fall_o,
    output logic [NUM_IO-1:0]    irq_status_o,
    output logic                 irq_o
);

    logic [NUM_IO-1:0] sync1_q;
    logic [NUM_IO-1:0] sync2_q;
    logic [NUM_IO-1:0] filt_q;
    logic [NUM_IO-1:0] filt_d;
    logic [NUM_IO-1:0] filt_prev_q;
    logic [NUM_IO-1:0] irq_q;
    logic [NUM_IO-1:0] irq_d;
    logic [NUM_IO-1:0] ev;

    // Synchroniser, filtered value, edge-detect history and irq status flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q     <= RST_VAL;
            sync2_q     <= RST_VAL;
            filt_q      <= RST_VAL;
            filt_prev_q <= RST_VAL;
            irq_q       <= '0;
        end else begin
            sync1_q     <= io_in_i;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            irq_q       <= irq_d;
        end
    end

    for (genvar n = 0; n < NUM_IO; n++) begin : g_pad
        logic [DEB_CNT_W-1:0] cnt_q;
        logic [DEB_CNT_W-1:0] cnt_d;
        logic [DEB_CNT_W:0]   cnt_inc;
        logic                 mism;
        logic                 filt_nxt;

        // Debounce: filtered value follows the synchronised value only after
        // it has disagreed for deb_limit_i consecutive cycles. The increment
        // is one bit wider so the >= compare can never see a wrapped count,
        // even when the limit is lowered mid-count.
        always_comb begin
            cnt_inc  = {1'b0, cnt_q} + {{DEB_CNT_W{1'b0}}, 1'b1};
            mism     = sync2_q[n] ^ filt_q[n];
            filt_nxt = filt_q[n];
            cnt_d    = cnt_q;
            if (!deb_en_i[n]) begin
                filt_nxt = sync2_q[n];
                cnt_d    = '0;
            end else if (!mism) begin
                cnt_d    = '0;
            end else if ((deb_limit_i == '0) || (cnt_inc >= {1'b0, deb_limit_i})) begin
                filt_nxt = sync2_q[n];
                cnt_d    = '0;
            end else begin
                cnt_d    = cnt_inc[DEB_CNT_W-1:0];
            end
        end

        assign filt_d[n] = filt_nxt;

        // Per-pad stable-cycle counter; reset discards any partial count
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Edge events feed status only for pads currently acting as inputs;
    // a set in the same cycle as a clear takes priority.
    always_comb begin
        ev    = io_oeb_i & ((rise_o & irq_rise_en_i) | (fall_o & irq_fall_en_i));
        irq_d = ev | (irq_q & ~irq_clr_i);
    end

    assign pin_sync_o   = sync2_q;
    assign pin_filt_o   = filt_q;
    assign rise_o       = filt_q & ~filt_prev_q;
    assign fall_o       = ~filt_q & filt_prev_q;
    assign irq_status_o = irq_q;
    assign irq_o        = |irq_q;

endmodule
`default_nettype wire
